// File: rtl/feature_fifo_out.sv
// Output FIFO for pooled feature pixels with occupancy flags, sticky overflow and frame-done pulse.
// Optional Almost_Full output when ALMOST_FULL_EN is defined.
module feature_fifo_out #(
  parameter int unsigned Datawidth  = 16,
  parameter int unsigned Depth      = 64,
  parameter int unsigned Frame_Size = 49,
  parameter int unsigned AF_Margin  = 4
) (
  input  logic                     CLK,
  input  logic                     CLR,
  input  logic [Datawidth-1:0]     In,
  input  logic                     Valid_IN,
  input  logic                     Rd_EN,
  output logic [Datawidth-1:0]     Out,
  output logic                     Valid_OUT,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(Depth):0]   Count,
  output logic                     Overflow,
`ifdef ALMOST_FULL_EN
  output logic                     Almost_Full,
`endif
  output logic                     Frame_Done
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = (Frame_Size > 1) ? $clog2(Frame_Size) : 1;
  localparam logic [CW-1:0] DepthC     = CW'(Depth);
  localparam logic [FW-1:0] FrameLastC = FW'(Frame_Size - 1);

  logic [Datawidth-1:0] mem_q [Depth];

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 overflow_q, overflow_d;
  logic [Datawidth-1:0] out_q, out_d;
  logic                 valid_out_q, valid_out_d;
  logic [FW-1:0]        frame_cnt_q, frame_cnt_d;
  logic                 frame_done_q, frame_done_d;
  logic                 rd_acc, wr_acc;

  // A read frees a slot in the same cycle, so a full FIFO may still accept a write.
  assign rd_acc = Rd_EN & ~empty_q;
  assign wr_acc = Valid_IN & (~full_q | rd_acc);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    out_d        = out_q;
    valid_out_d  = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (frame_cnt_q == FrameLastC) begin
        frame_cnt_d  = '0;
        frame_done_d = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
    if (rd_acc) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      out_d       = mem_q[rd_ptr_q];
      valid_out_d = 1'b1;
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CW'(1);
    end
    if (Valid_IN && !wr_acc) begin
      overflow_d = 1'b1;
    end
    full_d  = (count_d == DepthC);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      overflow_q   <= 1'b0;
      out_q        <= '0;
      valid_out_q  <= 1'b0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      overflow_q   <= overflow_d;
      out_q        <= out_d;
      valid_out_q  <= valid_out_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Storage is never cleared; pointers alone define validity.
  always_ff @(posedge CLK) begin
    if (CLR && wr_acc) begin
      mem_q[wr_ptr_q] <= In;
    end
  end

`ifdef ALMOST_FULL_EN
  localparam logic [CW-1:0] AfLevelC = CW'(Depth - AF_Margin);
  logic almost_full_q;

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= (count_d >= AfLevelC);
    end
  end

  assign Almost_Full = almost_full_q;
`endif

  assign Out        = out_q;
  assign Valid_OUT  = valid_out_q;
  assign Full       = full_q;
  assign Empty      = empty_q;
  assign Count      = count_q;
  assign Overflow   = overflow_q;
  assign Frame_Done = frame_done_q;

endmodule
